// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decode stage and the hazard scoreboard.
// master: decode (drives issue/source info, consumes stall/forward selects).
// slave : scoreboard (consumes issue/source info, drives stall/forward selects).
// Signals:
//   issue_valid, issue_wr_rd, issue_rd, issue_lat, issue_mc - decode instruction info
//   src_valid, src_reg                                      - packed source operands
//   flush                                                   - squash instruction entering EX
//   mc_done                                                 - multicycle result pulse
//   stall, mc_busy, fwd_sel                                 - scoreboard outputs
interface hazard_scoreboard_if #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 3,
    parameter int unsigned LAT_W      = 2
);
    localparam int unsigned SEL_W = $clog2(FWD_STAGES + 2);

    logic                       issue_valid;
    logic                       issue_wr_rd;
    logic [REG_W-1:0]           issue_rd;
    logic [LAT_W-1:0]           issue_lat;
    logic                       issue_mc;
    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC*REG_W-1:0]   src_reg;
    logic                       flush;
    logic                       mc_done;
    logic                       stall;
    logic                       mc_busy;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;

    modport master (
        output issue_valid, issue_wr_rd, issue_rd, issue_lat, issue_mc,
        output src_valid, src_reg, flush, mc_done,
        input  stall, mc_busy, fwd_sel
    );

    modport slave (
        input  issue_valid, issue_wr_rd, issue_rd, issue_lat, issue_mc,
        input  src_valid, src_reg, flush, mc_done,
        output stall, mc_busy, fwd_sel
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight register writers in a never-stalling
// shadow pipe (stages 1..FWD_STAGES = EX, MEM, WB, ...) with per-producer
// result latency, plus one outstanding variable-latency multicycle op.
// Produces per-operand bypass selects and the decode stall.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - hazard_scoreboard_if.slave (issue/source info in, stall/fwd_sel/mc_busy out)
//   perf_lu_stall, perf_mc_stall - saturating stall-cycle counters, present only
//                                  when HAZARD_PERF_CNT_EN is defined
// fwd_sel encoding per operand: 0 = register file, s = shadow stage s,
// FWD_STAGES+1 = multicycle result on its mc_done cycle.
module hazard_scoreboard #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 3,
    parameter int unsigned LAT_W      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_scoreboard_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_lu_stall,
    output logic [31:0]       perf_mc_stall
`endif
);
    localparam int unsigned SEL_W  = $clog2(FWD_STAGES + 2);
    localparam int unsigned CNT_W  = 32;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic [LAT_W-1:0] lat;
    } stage_t;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    stage_t                   stage_q [1:FWD_STAGES];
    stage_t                   stage1_d;
    mc_state_e                mc_state_q;
    logic [REG_W-1:0]         mc_rd_q;
    logic                     mc_busy_q;

    logic [REG_W-1:0]         sreg;
    logic                     rd_ok;
    logic                     op_lu;
    logic [SEL_W-1:0]         sel;
    logic                     lu_hazard;
    logic                     mc_raw;
    logic                     mc_conflict;
    logic                     stall_c;
    logic                     mc_go;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;

    // Operand match / forward select, stall and stage-1 load value.
    always_comb begin
        lu_hazard = 1'b0;
        mc_raw    = 1'b0;
        fwd_sel_c = '0;
        sreg      = '0;
        rd_ok     = 1'b0;
        op_lu     = 1'b0;
        sel       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sreg  = bus.src_reg[i*REG_W +: REG_W];
            rd_ok = bus.src_valid[i] && (sreg != '0);
            op_lu = 1'b0;
            sel   = '0;
            // Scan oldest to youngest so the lowest matching stage wins.
            for (int s = FWD_STAGES; s >= 1; s--) begin
                if (rd_ok && stage_q[s].v && (stage_q[s].rd == sreg)) begin
                    if (s >= int'(stage_q[s].lat)) begin
                        sel   = SEL_W'(s);
                        op_lu = 1'b0;
                    end else begin
                        sel   = '0;
                        op_lu = 1'b1;
                    end
                end
            end
            // An outstanding multicycle op is younger than any tracked writer
            // of the same register (later writers are held by the WAW stall).
            if (rd_ok && (mc_state_q == MC_BUSY) && (sreg == mc_rd_q)) begin
                op_lu = 1'b0;
                if (bus.mc_done) begin
                    sel = SEL_W'(FWD_STAGES + 1);
                end else begin
                    sel    = '0;
                    mc_raw = 1'b1;
                end
            end
            lu_hazard = lu_hazard | op_lu;
            fwd_sel_c[i*SEL_W +: SEL_W] = sel;
        end

        mc_conflict = (mc_state_q == MC_BUSY) &&
                      (mc_raw || bus.issue_mc ||
                       (bus.issue_wr_rd && (bus.issue_rd == mc_rd_q) &&
                        (mc_rd_q != '0) && !bus.mc_done));
        stall_c     = bus.issue_valid && (lu_hazard || mc_conflict);

        mc_go       = bus.issue_valid && bus.issue_mc && !stall_c && !bus.flush;

        stage1_d.v   = bus.issue_valid && bus.issue_wr_rd && !bus.issue_mc &&
                       !stall_c && !bus.flush && (bus.issue_rd != '0);
        stage1_d.rd  = bus.issue_rd;
        stage1_d.lat = bus.issue_lat;
    end

    // Shadow pipe: advances every cycle regardless of stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 1; s <= FWD_STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[1] <= stage1_d;
            for (int s = 2; s <= FWD_STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    // Multicycle unit tracker; mc_busy is the registered view of BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_state_q <= MC_IDLE;
            mc_rd_q    <= '0;
            mc_busy_q  <= 1'b0;
        end else begin
            case (mc_state_q)
                MC_IDLE: begin
                    if (mc_go) begin
                        mc_state_q <= MC_BUSY;
                        mc_busy_q  <= 1'b1;
                        mc_rd_q    <= bus.issue_wr_rd ? bus.issue_rd : '0;
                    end
                end
                MC_BUSY: begin
                    if (bus.mc_done) begin
                        mc_state_q <= MC_IDLE;
                        mc_busy_q  <= 1'b0;
                    end
                end
                default: begin
                    mc_state_q <= MC_IDLE;
                    mc_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall   = stall_c;
    assign bus.fwd_sel = fwd_sel_c;
    assign bus.mc_busy = mc_busy_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu_q;
    logic [CNT_W-1:0] perf_mc_q;

    // Saturating stall-cause counters; a cycle with both causes bumps both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q <= '0;
            perf_mc_q <= '0;
        end else begin
            if (bus.issue_valid && lu_hazard && (perf_lu_q != '1)) begin
                perf_lu_q <= perf_lu_q + CNT_W'(1);
            end
            if (bus.issue_valid && mc_conflict && (perf_mc_q != '1)) begin
                perf_mc_q <= perf_mc_q + CNT_W'(1);
            end
        end
    end

    assign perf_lu_stall = perf_lu_q;
    assign perf_mc_stall = perf_mc_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-scenario tasks drive one
// instruction per cycle, push the expected outputs to a scoreboard queue and
// pop/compare them mid-cycle.
module tb_hazard_scoreboard;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned FWD_STAGES = 3;
    localparam int unsigned LAT_W      = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC),
                           .FWD_STAGES(FWD_STAGES), .LAT_W(LAT_W)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_stall;
    logic [31:0] perf_mc_stall;
`endif

    hazard_scoreboard #(.REG_W(REG_W), .NUM_SRC(NUM_SRC),
                        .FWD_STAGES(FWD_STAGES), .LAT_W(LAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_stall (perf_lu_stall),
        .perf_mc_stall (perf_mc_stall)
`endif
    );

    typedef struct {
        logic       iv;
        logic       wr;
        logic [4:0] rd;
        logic [1:0] lat;
        logic       mc;
        logic [1:0] sv;
        logic [4:0] s0;
        logic [4:0] s1;
        logic       fl;
        logic       dn;
    } stim_t;

    typedef struct {
        string      name;
        logic       stall;
        logic [2:0] f0;
        logic [2:0] f1;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic stim_t mk(logic iv, logic wr, logic [4:0] rd, logic [1:0] lat,
                                 logic mc, logic [1:0] sv, logic [4:0] s0,
                                 logic [4:0] s1, logic fl, logic dn);
        stim_t t;
        t.iv = iv; t.wr = wr; t.rd = rd; t.lat = lat; t.mc = mc;
        t.sv = sv; t.s0 = s0; t.s1 = s1; t.fl = fl; t.dn = dn;
        return t;
    endfunction

    function automatic exp_t ex(string name, logic stall, logic [2:0] f0,
                                logic [2:0] f1, logic busy);
        exp_t e;
        e.name = name; e.stall = stall; e.f0 = f0; e.f1 = f1; e.busy = busy;
        return e;
    endfunction

    task automatic apply(input stim_t t);
        bus.issue_valid = t.iv;
        bus.issue_wr_rd = t.wr;
        bus.issue_rd    = t.rd;
        bus.issue_lat   = t.lat;
        bus.issue_mc    = t.mc;
        bus.src_valid   = t.sv;
        bus.src_reg     = {t.s1, t.s0};
        bus.flush       = t.fl;
        bus.mc_done     = t.dn;
    endtask

    // Quiet cycles to drain the shadow pipe.
    task automatic idle(input int n);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        apply(mk(1, 1, 5'd3, 2'd1, 0, 2'b11, 5'd3, 5'd4, 0, 1));
        exp_q.push_back(ex("reset_state", 0, 0, 0, 0));
        #5;
        e = exp_q.pop_front(); n_run++;
        if ({bus.stall, bus.fwd_sel, bus.mc_busy} !== {e.stall, e.f1, e.f0, e.busy}) begin
            n_fail++;
            $display("FAIL %s: got stall=%b fwd=%0d/%0d busy=%b, want stall=%b fwd=%0d/%0d busy=%b",
                     e.name, bus.stall, bus.fwd_sel[2:0], bus.fwd_sel[5:3], bus.mc_busy,
                     e.stall, e.f0, e.f1, e.busy);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_alu_fwd();
        stim_t st[$]; exp_t xe[$]; exp_t e;
        idle(4);
        st.push_back(mk(1, 1, 5'd5, 2'd1, 0, 2'b00, 0, 0, 0, 0)); xe.push_back(ex("alu_issue", 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b01, 5'd5, 0, 0, 0));  xe.push_back(ex("alu_fwd_ex", 0, 1, 0, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b11, 0, 5'd5, 0, 0));  xe.push_back(ex("alu_fwd_mem", 0, 0, 2, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b01, 5'd5, 0, 0, 0));  xe.push_back(ex("alu_fwd_wb", 0, 3, 0, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b01, 5'd5, 0, 0, 0));  xe.push_back(ex("alu_retired", 0, 0, 0, 0));
        foreach (st[k]) begin
            apply(st[k]); exp_q.push_back(xe[k]);
            #5;
            e = exp_q.pop_front(); n_run++;
            if ({bus.stall, bus.fwd_sel, bus.mc_busy} !== {e.stall, e.f1, e.f0, e.busy}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fwd=%0d/%0d busy=%b, want stall=%b fwd=%0d/%0d busy=%b",
                         e.name, bus.stall, bus.fwd_sel[2:0], bus.fwd_sel[5:3], bus.mc_busy,
                         e.stall, e.f0, e.f1, e.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[$]; exp_t xe[$]; exp_t e;
        idle(4);
        st.push_back(mk(1, 1, 5'd6, 2'd2, 0, 2'b00, 0, 0, 0, 0)); xe.push_back(ex("load_issue", 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b01, 5'd6, 0, 0, 0));  xe.push_back(ex("load_use_stall", 1, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b01, 5'd6, 0, 0, 0));  xe.push_back(ex("load_use_fwd_mem", 0, 2, 0, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b10, 0, 5'd6, 0, 0));  xe.push_back(ex("load_fwd_wb", 0, 0, 3, 0));
        foreach (st[k]) begin
            apply(st[k]); exp_q.push_back(xe[k]);
            #5;
            e = exp_q.pop_front(); n_run++;
            if ({bus.stall, bus.fwd_sel, bus.mc_busy} !== {e.stall, e.f1, e.f0, e.busy}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fwd=%0d/%0d busy=%b, want stall=%b fwd=%0d/%0d busy=%b",
                         e.name, bus.stall, bus.fwd_sel[2:0], bus.fwd_sel[5:3], bus.mc_busy,
                         e.stall, e.f0, e.f1, e.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_youngest();
        stim_t st[$]; exp_t xe[$]; exp_t e;
        idle(4);
        st.push_back(mk(1, 1, 5'd7, 2'd1, 0, 2'b00, 0, 0, 0, 0));    xe.push_back(ex("young_w1", 0, 0, 0, 0));
        st.push_back(mk(1, 1, 5'd7, 2'd1, 0, 2'b10, 0, 5'd7, 0, 0)); xe.push_back(ex("young_w2_reads", 0, 0, 1, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b11, 5'd7, 5'd7, 0, 0)); xe.push_back(ex("young_wins", 0, 1, 1, 0));
        st.push_back(mk(1, 1, 5'd7, 2'd2, 0, 2'b00, 0, 0, 0, 0));    xe.push_back(ex("young_load", 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b01, 5'd7, 0, 0, 0));    xe.push_back(ex("young_load_stall", 1, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b01, 5'd7, 0, 0, 0));    xe.push_back(ex("young_load_fwd", 0, 2, 0, 0));
        foreach (st[k]) begin
            apply(st[k]); exp_q.push_back(xe[k]);
            #5;
            e = exp_q.pop_front(); n_run++;
            if ({bus.stall, bus.fwd_sel, bus.mc_busy} !== {e.stall, e.f1, e.f0, e.busy}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fwd=%0d/%0d busy=%b, want stall=%b fwd=%0d/%0d busy=%b",
                         e.name, bus.stall, bus.fwd_sel[2:0], bus.fwd_sel[5:3], bus.mc_busy,
                         e.stall, e.f0, e.f1, e.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        stim_t st[$]; exp_t xe[$]; exp_t e;
        idle(4);
        st.push_back(mk(1, 1, 5'd9, 2'd1, 0, 2'b00, 0, 0, 1, 0));  xe.push_back(ex("flush_alu", 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b01, 5'd9, 0, 0, 0));  xe.push_back(ex("flush_no_fwd", 0, 0, 0, 0));
        st.push_back(mk(1, 1, 5'd9, 2'd1, 1, 2'b00, 0, 0, 1, 0));  xe.push_back(ex("flush_mc", 0, 0, 0, 0));
        st.push_back(mk(1, 1, 5'd9, 2'd1, 1, 2'b00, 0, 0, 0, 0));  xe.push_back(ex("flush_mc_not_busy", 0, 0, 0, 0));
        st.push_back(mk(0, 0, 0, 2'd1, 0, 2'b00, 0, 0, 1, 1));     xe.push_back(ex("mc_busy_despite_flush", 0, 0, 0, 1));
        st.push_back(mk(0, 0, 0, 2'd1, 0, 2'b00, 0, 0, 0, 0));     xe.push_back(ex("mc_released", 0, 0, 0, 0));
        foreach (st[k]) begin
            apply(st[k]); exp_q.push_back(xe[k]);
            #5;
            e = exp_q.pop_front(); n_run++;
            if ({bus.stall, bus.fwd_sel, bus.mc_busy} !== {e.stall, e.f1, e.f0, e.busy}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fwd=%0d/%0d busy=%b, want stall=%b fwd=%0d/%0d busy=%b",
                         e.name, bus.stall, bus.fwd_sel[2:0], bus.fwd_sel[5:3], bus.mc_busy,
                         e.stall, e.f0, e.f1, e.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_multicycle();
        stim_t st[$]; exp_t xe[$]; exp_t e;
        idle(4);
        st.push_back(mk(1, 1, 5'd8, 2'd1, 1, 2'b00, 0, 0, 0, 0)); xe.push_back(ex("div_issue", 0, 0, 0, 0));
        for (int c = 1; c <= 9; c++) begin
            st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b01, 5'd8, 0, 0, 0));
            xe.push_back(ex($sformatf("div_raw_stall_c%0d", c), 1, 0, 0, 1));
        end
        st.push_back(mk(1, 0, 0, 2'd1, 0, 2'b01, 5'd8, 0, 0, 1)); xe.push_back(ex("div_done_fwd", 0, 4, 0, 1));
        st.push_back(mk(0, 0, 0, 2'd1, 0, 2'b00, 0, 0, 0, 0));    xe.push_back(ex("div_idle", 0, 0, 0, 0));
        foreach (st[k]) begin
            apply(st[k]); exp_q.push_back(xe[k]);
            #5;
            e = exp_q.pop_front(); n_run++;
            if ({bus.stall, bus.fwd_sel, bus.mc_busy} !== {e.stall, e.f1, e.f0, e.busy}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fwd=%0d/%0d busy=%b, want stall=%b fwd=%0d/%0d busy=%b",
                         e.name, bus.stall, bus.fwd_sel[2:0], bus.fwd_sel[5:3], bus.mc_busy,
                         e.stall, e.f0, e.f1, e.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_conflicts();
        stim_t st[$]; exp_t xe[$]; exp_t e;
        idle(4);
        st.push_back(mk(1, 1, 5'd8,  2'd1, 1, 2'b00, 0, 0, 0, 0)); xe.push_back(ex("bc_mc_issue", 0, 0, 0, 0));
        st.push_back(mk(1, 1, 5'd10, 2'd1, 1, 2'b00, 0, 0, 0, 0)); xe.push_back(ex("bc_second_mc", 1, 0, 0, 1));
        st.push_back(mk(1, 1, 5'd8,  2'd1, 0, 2'b00, 0, 0, 0, 0)); xe.push_back(ex("bc_waw", 1, 0, 0, 1));
        st.push_back(mk(1, 1, 5'd0,  2'd1, 0, 2'b11, 0, 0, 0, 0)); xe.push_back(ex("bc_x0_read", 0, 0, 0, 1));
        st.push_back(mk(1, 1, 5'd10, 2'd1, 1, 2'b00, 0, 0, 0, 1)); xe.push_back(ex("bc_mc_done_same_cycle", 1, 0, 0, 1));
        st.push_back(mk(1, 1, 5'd11, 2'd1, 1, 2'b00, 0, 0, 0, 0)); xe.push_back(ex("bc_mc_reissue", 0, 0, 0, 0));
        st.push_back(mk(1, 1, 5'd11, 2'd1, 0, 2'b00, 0, 0, 0, 1)); xe.push_back(ex("bc_waw_on_done", 0, 0, 0, 1));
        st.push_back(mk(1, 0, 0,     2'd1, 0, 2'b10, 0, 5'd11, 0, 1)); xe.push_back(ex("bc_idle_done_ignored", 0, 0, 1, 0));
        st.push_back(mk(0, 0, 0,     2'd1, 0, 2'b00, 0, 0, 0, 0)); xe.push_back(ex("bc_still_idle", 0, 0, 0, 0));
        foreach (st[k]) begin
            apply(st[k]); exp_q.push_back(xe[k]);
            #5;
            e = exp_q.pop_front(); n_run++;
            if ({bus.stall, bus.fwd_sel, bus.mc_busy} !== {e.stall, e.f1, e.f0, e.busy}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fwd=%0d/%0d busy=%b, want stall=%b fwd=%0d/%0d busy=%b",
                         e.name, bus.stall, bus.fwd_sel[2:0], bus.fwd_sel[5:3], bus.mc_busy,
                         e.stall, e.f0, e.f1, e.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_busy();
        stim_t st[$]; exp_t xe[$]; exp_t e;
        idle(4);
        // Cycle plan: mc x12, load x13, consumer (then async reset mid-cycle),
        // held reset, stale mc_done, quiet.
        st.push_back(mk(1, 1, 5'd12, 2'd1, 1, 2'b00, 0, 0, 0, 0));         xe.push_back(ex("rst_mc_issue", 0, 0, 0, 0));
        st.push_back(mk(1, 1, 5'd13, 2'd2, 0, 2'b00, 0, 0, 0, 0));         xe.push_back(ex("rst_load_issue", 0, 0, 0, 1));
        st.push_back(mk(1, 0, 0,     2'd1, 0, 2'b11, 5'd12, 5'd13, 0, 0)); xe.push_back(ex("rst_pre_stall", 1, 0, 0, 1));
        xe.push_back(ex("rst_async_clear", 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0,     2'd1, 0, 2'b01, 5'd12, 0, 0, 1));     xe.push_back(ex("rst_stale_done", 0, 0, 0, 0));
        st.push_back(mk(0, 0, 0,     2'd1, 0, 2'b00, 0, 0, 0, 0));         xe.push_back(ex("rst_stays_idle", 0, 0, 0, 0));
        for (int k = 0; k < 6; k++) begin
            if (k != 3) apply(st[(k > 3) ? k - 1 : k]);
            if (k == 3) begin
                rst_n = 1'b0;
                #1;
            end
            exp_q.push_back(xe[k]);
            if (k != 3) #5;
            e = exp_q.pop_front(); n_run++;
            if ({bus.stall, bus.fwd_sel, bus.mc_busy} !== {e.stall, e.f1, e.f0, e.busy}) begin
                n_fail++;
                $display("FAIL %s: got stall=%b fwd=%0d/%0d busy=%b, want stall=%b fwd=%0d/%0d busy=%b",
                         e.name, bus.stall, bus.fwd_sel[2:0], bus.fwd_sel[5:3], bus.mc_busy,
                         e.stall, e.f0, e.f1, e.busy);
            end
            if (k == 3) begin
                @(posedge clk); #3;
                rst_n = 1'b1;
                @(posedge clk); #1;
            end else if (k != 2) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_flush();
        test_multicycle();
        test_busy_conflicts();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage hazard controller.
- Tracks in-flight register writers in a FWD_STAGES-deep shadow pipeline with per-producer result latency, and generates per-operand forward selects and a decode stall.
- Adds one variable-latency multicycle unit (mul/div) tracked with a busy/done handshake.
- Sits beside decode; drives operand bypass muxes and the IF/ID and ID/EX stall enables.

Parameters:
- REG_W, 5, register index width; x0 = index 0 is never tracked.
- NUM_SRC, 2, number of decode source operands checked.
- FWD_STAGES, 3, tracked stages after decode (1=EX, 2=MEM, 3=WB).
- LAT_W, 2, width of the per-instruction latency field.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  decode holds a valid instruction
- issue_wr_rd  in  1  decode instruction writes rd
- issue_rd  in  REG_W  decode destination
- issue_lat  in  LAT_W  first stage where the result is forwardable (1=ALU, 2=load)
- issue_mc  in  1  decode instruction goes to the multicycle unit
- src_valid  in  NUM_SRC  per-operand "reads register"
- src_reg  in  NUM_SRC*REG_W  packed source indices
- flush  in  1  squash the instruction entering EX this cycle
- mc_done  in  1  single-cycle pulse: multicycle result valid
- stall  out  1  hold IF/ID and ID/EX; insert bubble
- mc_busy  out  1  multicycle op outstanding
- fwd_sel  out  NUM_SRC*SEL_W  per operand; SEL_W = clog2(FWD_STAGES+2)

Behaviour:
- Shadow pipe: stages 1..FWD_STAGES, each holding {v, rd, lat}. It advances every cycle and never stalls.
- Stage 1 load value: {issue_valid & issue_wr_rd & !issue_mc & !stall & !flush & rd!=0, issue_rd, issue_lat}. Otherwise stage 1 loads v=0.
- Operand match: src_valid[i] & src_reg[i]!=0 & stage v & stage rd==src_reg[i].
- Priority is youngest first; the lowest matching stage number wins.
- Forwarding, combinational:
  - Youngest match at stage s with s>=lat gives fwd_sel=s.
  - Youngest match with s<lat is a load-use hazard: stall=1 and fwd_sel=0.
  - No match gives fwd_sel=0 (RF).
  - A multicycle match on the cycle mc_done=1 gives fwd_sel=FWD_STAGES+1.
- Multicycle FSM has two states, IDLE and BUSY. mc_busy=1 exactly when in BUSY.
  - IDLE to BUSY: issue_valid & issue_mc & !stall & !flush. Capture mc_rd (0 if !issue_wr_rd).
  - BUSY to IDLE: on mc_done. The result is written to the RF the same cycle.
  - mc_done while IDLE is ignored.
- Stall is the OR of:
  - the load-use hazard;
  - BUSY & operand reads mc_rd (mc_rd!=0) & !mc_done;
  - BUSY & issue_mc (single outstanding op; a same-cycle mc_done does not release it);
  - BUSY & issue_wr_rd & issue_rd==mc_rd!=0 & !mc_done (WAW).
- Stall is gated by issue_valid; a stalled cycle inserts a bubble into stage 1.
- flush forces a bubble into stage 1 and blocks the IDLE to BUSY transition. It does not affect older stages or an already-BUSY op.
- Reset (asynchronous, any time):
  - All stage v=0; FSM=IDLE; mc_rd=0.
  - Outputs: stall=0, mc_busy=0, fwd_sel=0.
  - An outstanding op is abandoned; a later mc_done is ignored.
- All outputs except mc_busy are combinational from inputs and state. mc_busy is registered.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs perf_lu_stall (32) and perf_mc_stall (32). These are saturating counters of stall cycles caused by load-use and by multicycle conditions respectively; a cycle with both causes increments both. Both reset to 0 on rst_n.
- When not defined, the ports, counters and logic are absent.

Test Plan:
- ALU x5 (lat=1) issued, consumer reads x5 next cycle → stall=0, fwd_sel=1; one cycle later → fwd_sel=2.
- Load x6 (lat=2), consumer reads x6 next cycle → exactly one stall cycle, then fwd_sel=2, stall=0.
- Two writers of x7 at stages 1 and 2, consumer reads x7 → fwd_sel=1 (youngest wins).
- Divide to x8, mc_done after 10 cycles, consumer reads x8 → stall held until mc_done, fwd_sel=4 on the mc_done cycle; mc_busy 1→0.
- BUSY with a second issue_mc, plus a write to x8 while mc_rd=x8 → both stall; a read of x0 never stalls or forwards.
- rst_n dropped mid-BUSY with a stage-1 load pending → all outputs 0 immediately; a stale mc_done after release → no effect.
